// File: rtl/incoming_event_sched.sv
// incoming_event_sched: arbitrates ACK / timeout events onto one shared
// user-logic instance through a read / update / write-back context pipeline.
// Ports:
//   ack_*      ACK requests (valid/ready, flow id, payload)
//   to_*       timeout requests (valid/ready, flow id)
//   ctx_rd_*   context RAM read, data returns one cycle after ctx_rd_en
//   udl_*      user logic inputs (stage B) and its combinational result
//   ctx_wr_*   context RAM write-back (stage C)
//   done_*     retirement strobe, same cycle as the write
//   ack_cnt / to_cnt   retired event counters, wrapping
module incoming_event_sched #(
  parameter int FLOW_ID_W = 10,
  parameter int CTX_W     = 256,
  parameter int EVT_W     = 64,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ack_valid,
  output logic                 ack_ready,
  input  logic [FLOW_ID_W-1:0] ack_flow_id,
  input  logic [EVT_W-1:0]     ack_evt,
  input  logic                 to_valid,
  output logic                 to_ready,
  input  logic [FLOW_ID_W-1:0] to_flow_id,
  output logic                 ctx_rd_en,
  output logic [FLOW_ID_W-1:0] ctx_rd_addr,
  input  logic [CTX_W-1:0]     ctx_rd_data,
  output logic                 udl_valid,
  output logic                 udl_is_timeout,
  output logic [EVT_W-1:0]     udl_evt,
  output logic [CTX_W-1:0]     udl_ctx_in,
  input  logic [CTX_W-1:0]     udl_ctx_out,
  output logic                 ctx_wr_en,
  output logic [FLOW_ID_W-1:0] ctx_wr_addr,
  output logic [CTX_W-1:0]     ctx_wr_data,
  output logic                 done_valid,
  output logic [FLOW_ID_W-1:0] done_flow_id,
  output logic [CNT_W-1:0]     ack_cnt,
  output logic [CNT_W-1:0]     to_cnt
);

  logic                 b_vld;
  logic                 b_to;
  logic [FLOW_ID_W-1:0] b_flow;
  logic [EVT_W-1:0]     b_evt;
  logic                 c_vld;
  logic                 c_to;
  logic [FLOW_ID_W-1:0] c_flow;
  logic [CTX_W-1:0]     c_data;
  logic                 rr_to;
  logic [CNT_W-1:0]     ack_q;
  logic [CNT_W-1:0]     to_q;
  logic                 ack_ok;
  logic                 to_ok;
  logic                 gnt_ack;
  logic                 gnt_to;
  logic                 gnt;
  logic                 wr;

  // A flow is blocked while an earlier event for it sits in B or C,
  // so the read never sees a stale context.
  assign ack_ok = !rst && ack_valid
                && !(b_vld && ack_flow_id == b_flow)
                && !(c_vld && ack_flow_id == c_flow);
  assign to_ok  = !rst && to_valid
                && !(b_vld && to_flow_id == b_flow)
                && !(c_vld && to_flow_id == c_flow);

  always_comb begin
    gnt_ack = 1'b0;
    gnt_to  = 1'b0;
    unique case (1'b1)
      (ack_ok && to_ok): begin
        gnt_to  = rr_to;
        gnt_ack = !rr_to;
      end
      (ack_ok && !to_ok): gnt_ack = 1'b1;
      (!ack_ok && to_ok): gnt_to  = 1'b1;
      default: ;
    endcase
  end

  assign gnt       = gnt_ack | gnt_to;
  assign ack_ready = gnt_ack;
  assign to_ready  = gnt_to;
  assign ctx_rd_en = gnt;
  assign ctx_rd_addr = gnt_to  ? to_flow_id
                     : gnt_ack ? ack_flow_id
                     : '0;

  assign udl_valid      = b_vld && !rst;
  assign udl_is_timeout = udl_valid && b_to;
  assign udl_evt        = udl_valid ? b_evt : '0;
  assign udl_ctx_in     = udl_valid ? ctx_rd_data : '0;

  assign wr           = c_vld && !rst;
  assign ctx_wr_en    = wr;
  assign ctx_wr_addr  = wr ? c_flow : '0;
  assign ctx_wr_data  = wr ? c_data : '0;
  assign done_valid   = wr;
  assign done_flow_id = wr ? c_flow : '0;
  assign ack_cnt      = rst ? '0 : ack_q;
  assign to_cnt       = rst ? '0 : to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_vld  <= 1'b0;
      b_to   <= 1'b0;
      b_flow <= '0;
      b_evt  <= '0;
      c_vld  <= 1'b0;
      c_to   <= 1'b0;
      c_flow <= '0;
      c_data <= '0;
      rr_to  <= 1'b0;
      ack_q  <= '0;
      to_q   <= '0;
    end else begin
      b_vld <= gnt;
      if (gnt) begin
        b_flow <= gnt_to ? to_flow_id : ack_flow_id;
        b_to   <= gnt_to;
        b_evt  <= gnt_to ? '0 : ack_evt;
      end
      c_vld <= b_vld;
      if (b_vld) begin
        c_flow <= b_flow;
        c_to   <= b_to;
        c_data <= udl_ctx_out;
      end
      // pointer only moves when both sides actually competed
      if (ack_ok && to_ok)
        rr_to <= !rr_to;
      if (c_vld) begin
        if (c_to)
          to_q <= to_q + CNT_W'(1);
        else
          ack_q <= ack_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/incoming_event_sched.md
Name: incoming_event_sched

Overview:
- Arbitrates between the ACK-event stream and the timeout-event stream for one shared instance of the per-flow user-defined incoming logic.
- Sequences each granted event through a 3-stage read-modify-write of the per-flow context memory: read, combinational update, write-back.
- Sits between the incoming packet parser / timer wheel and the flow context RAM.
- Guarantees that no two in-flight events touch the same flow.

Parameters:
- FLOW_ID_W, 10, flow index width (context RAM address width).
- CTX_W, 256, packed per-flow context width (window, timers, user context).
- EVT_W, 64, packed event payload width (pkt type, cumulative/selective ack, tx id).
- CNT_W, 32, event counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ack_valid  in  1  ACK event request.
- ack_ready  out  1  ACK event accepted this cycle.
- ack_flow_id  in  FLOW_ID_W  ACK target flow.
- ack_evt  in  EVT_W  ACK payload.
- to_valid  in  1  timeout event request.
- to_ready  out  1  timeout event accepted this cycle.
- to_flow_id  in  FLOW_ID_W  timeout target flow.
- ctx_rd_en  out  1  context RAM read strobe.
- ctx_rd_addr  out  FLOW_ID_W  read address.
- ctx_rd_data  in  CTX_W  read data, valid exactly 1 cycle after ctx_rd_en.
- udl_valid  out  1  user logic inputs valid (stage B).
- udl_is_timeout  out  1  stage-B event is a timeout.
- udl_evt  out  EVT_W  stage-B event payload (zero for timeouts).
- udl_ctx_in  out  CTX_W  context presented to user logic.
- udl_ctx_out  in  CTX_W  updated context, combinational from user logic.
- ctx_wr_en  out  1  context write strobe.
- ctx_wr_addr  out  FLOW_ID_W  write address.
- ctx_wr_data  out  CTX_W  write data.
- done_valid  out  1  event retired (same cycle as write).
- done_flow_id  out  FLOW_ID_W  retired flow.
- ack_cnt  out  CNT_W  retired ACK events.
- to_cnt  out  CNT_W  retired timeout events.

Behaviour:
- Reset: all outputs 0. Stage valids B and C cleared, round-robin pointer set to ACK, counters 0. Reset mid-operation drops in-flight events with no write issued; the cycle after rst deasserts behaves as fresh.
- Stage A (grant, same cycle as request):
  - Requester X is eligible if X_valid and X_flow_id matches neither valid stage-B flow nor valid stage-C flow.
  - One eligible requester: grant it.
  - Both eligible: grant the requester indicated by the RR pointer, then point the pointer at the other requester.
  - Pointer changes only on a contested grant.
  - On grant: ready=1 for the winner only; ctx_rd_en=1; ctx_rd_addr=winner flow; flow/type/payload latched into stage B.
  - No grant: ctx_rd_en=0; both readys 0. The ineligible requester keeps waiting.
- Stage B (+1 cycle): udl_valid=1; udl_ctx_in=ctx_rd_data (unregistered passthrough); udl_evt/udl_is_timeout from the stage-B register. udl_ctx_out is latched into stage C along with the flow id.
- Stage C (+2 cycles): ctx_wr_en=1; addr/data from stage-C registers; done_valid=1; matching counter +1, wrapping modulo 2^CNT_W.
- Latency: accept to write is exactly 2 cycles. Throughput is 1 event/cycle when consecutive events hit distinct flows.
- Hazard rule: a same-flow event waits until the prior event for that flow has left stage C. Back-to-back same-flow events therefore space at 3 cycles (accept at t, next accept at t+3). A read issued in the same cycle as a write to a different address is legal.
- ready never asserts without valid. Payload must be held stable while valid && !ready.
- The pipeline never back-pressures internally: stages B and C always advance.

Test Plan:
- Single ACK, flow 5, ctx_rd_data=0xAA.., udl_ctx_out=ctx+1 -> ack_ready at t0, ctx_rd_addr=5 at t0, ctx_wr_en/addr=5/data=0xAA..+1 at t0+2, ack_cnt=1.
- ACK flow 7 on 4 consecutive cycles -> accepts at t0, t0+3, t0+6, t0+9. Each read occurs after the previous write to flow 7.
- ACK and timeout both valid every cycle, distinct rotating flows -> grants alternate ACK, TO, ACK, TO…; after 10 retirements ack_cnt=5, to_cnt=5; one write per cycle.
- ACK flow 3 in flight (stage B); timeout flow 3 and ACK flow 4 requested -> ACK 4 granted, timeout waits and is granted once flow 3 leaves stage C.
- rst asserted at t0+1 after accepting flow 9 -> no ctx_wr_en for flow 9, counters 0, readys 0 during reset, normal grant on the first cycle after release.
- ack_cnt preset near wrap (CNT_W=4 build, 16 ACKs) -> ack_cnt returns to 0.
